// File: rtl/uart_rx_fifo.sv
// UART receiver with oversampled 3-tap majority voting, per-frame error flags
// and a small FIFO presenting frames on a valid/ready stream.
module uart_rx_fifo #(
  parameter int DATA_BITS  = 8,
  parameter int PAR_MODE   = 1,
  parameter int STOP_BITS  = 1,
  parameter int OVS        = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          tick,
  input  logic                          rx,
  output logic [DATA_BITS-1:0]          m_data,
  output logic                          m_par_err,
  output logic                          m_frm_err,
  output logic                          m_brk,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overrun,
  input  logic                          clr_ovr
);

  localparam int TW = $clog2(OVS);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;
  localparam int EW = DATA_BITS + 3;

  localparam logic [TW-1:0] T_S0  = TW'(OVS/2 - 1);
  localparam logic [TW-1:0] T_S1  = TW'(OVS/2);
  localparam logic [TW-1:0] T_DEC = TW'(OVS/2 + 1);
  localparam logic [TW-1:0] T_END = TW'(OVS - 1);
  localparam logic [3:0]    LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0]    LAST_STOP = 4'(STOP_BITS - 1);
  localparam logic [LW-1:0] FULL_LVL  = LW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BRK_WAIT
  } state_e;

  logic                 rx_meta_q, rx_meta_d;
  logic                 rx_s_q, rx_s_d;
  logic                 rx_prev_q, rx_prev_d;
  state_e               state_q, state_d;
  logic [TW-1:0]        tick_cnt_q, tick_cnt_d;
  logic [3:0]           bit_cnt_q, bit_cnt_d;
  logic [1:0]           samp_q, samp_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_bit_q, par_bit_d;
  logic                 frm_err_q, frm_err_d;
  logic                 stop_zero_q, stop_zero_d;

  logic [EW-1:0]        mem_q [FIFO_DEPTH];
  logic [EW-1:0]        mem_d [FIFO_DEPTH];
  logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]        level_q, level_d;
  logic                 overrun_q, overrun_d;

  logic                 vote, is_dec, is_end, brk, par_calc, par_err;
  logic                 push, pop, full, wr_en;
  logic [EW-1:0]        push_entry;

  // Receiver FSM and bit timing
  always_comb begin
    rx_meta_d   = rx;
    rx_s_d      = rx_meta_q;
    rx_prev_d   = rx_s_q;
    state_d     = state_q;
    tick_cnt_d  = tick_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    samp_d      = samp_q;
    shift_d     = shift_q;
    par_bit_d   = par_bit_q;
    frm_err_d   = frm_err_q;
    stop_zero_d = stop_zero_q;
    push        = 1'b0;
    push_entry  = '0;
    brk         = 1'b0;

    // Third sample is rx_s itself on the decision tick.
    vote   = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s_q) | (samp_q[1] & rx_s_q);
    is_dec = tick && (tick_cnt_q == T_DEC);
    is_end = tick && (tick_cnt_q == T_END);

    par_calc = (^shift_q) ^ par_bit_q;
    if (PAR_MODE == 1)      par_err = par_calc;
    else if (PAR_MODE == 2) par_err = ~par_calc;
    else                    par_err = 1'b0;

    if (tick && state_q != S_IDLE && state_q != S_BRK_WAIT) begin
      tick_cnt_d = (tick_cnt_q == T_END) ? '0 : tick_cnt_q + 1'b1;
      if (tick_cnt_q == T_S0) samp_d[0] = rx_s_q;
      if (tick_cnt_q == T_S1) samp_d[1] = rx_s_q;
    end

    case (state_q)
      S_IDLE: begin
        if (rx_prev_q && !rx_s_q) begin
          state_d     = S_START;
          tick_cnt_d  = '0;
          bit_cnt_d   = '0;
          par_bit_d   = 1'b0;
          frm_err_d   = 1'b0;
          stop_zero_d = 1'b1;
        end
      end
      S_START: begin
        if (is_dec && vote) state_d = S_IDLE;
        else if (is_end)    state_d = S_DATA;
      end
      S_DATA: begin
        if (is_dec) shift_d = {vote, shift_q[DATA_BITS-1:1]};
        if (is_end) begin
          if (bit_cnt_q == LAST_DATA) begin
            bit_cnt_d = '0;
            state_d   = (PAR_MODE != 0) ? S_PARITY : S_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      S_PARITY: begin
        if (is_dec) par_bit_d = vote;
        if (is_end) state_d = S_STOP;
      end
      S_STOP: begin
        if (is_dec) begin
          if (!vote) frm_err_d = 1'b1;
          stop_zero_d = stop_zero_q & ~vote;
          // Push on the final decision tick rather than waiting out the window.
          if (bit_cnt_q == LAST_STOP) begin
            brk        = (shift_q == '0) && !par_bit_q && stop_zero_q && !vote;
            push       = 1'b1;
            push_entry = {brk, brk | frm_err_q | ~vote, par_err, shift_q};
            state_d    = brk ? S_BRK_WAIT : S_IDLE;
          end
        end else if (is_end) begin
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
      S_BRK_WAIT: begin
        if (tick && rx_s_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FIFO: a push into a full FIFO only lands when the head is popped that cycle.
  always_comb begin
    pop   = (level_q != '0) && m_ready;
    full  = (level_q == FULL_LVL);
    wr_en = push && (!full || pop);
    mem_d = mem_q;
    if (wr_en) mem_d[wr_ptr_q] = push_entry;
    wr_ptr_d  = wr_ptr_q + PW'(wr_en);
    rd_ptr_d  = rd_ptr_q + PW'(pop);
    level_d   = level_q + LW'(wr_en) - LW'(pop);
    overrun_d = overrun_q;
    if (push && full && !pop) overrun_d = 1'b1;
    else if (clr_ovr)         overrun_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q   <= 1'b1;
      rx_s_q      <= 1'b1;
      rx_prev_q   <= 1'b1;
      state_q     <= S_IDLE;
      tick_cnt_q  <= '0;
      bit_cnt_q   <= '0;
      samp_q      <= '0;
      shift_q     <= '0;
      par_bit_q   <= 1'b0;
      frm_err_q   <= 1'b0;
      stop_zero_q <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      overrun_q   <= 1'b0;
    end else begin
      rx_meta_q   <= rx_meta_d;
      rx_s_q      <= rx_s_d;
      rx_prev_q   <= rx_prev_d;
      state_q     <= state_d;
      tick_cnt_q  <= tick_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      samp_q      <= samp_d;
      shift_q     <= shift_d;
      par_bit_q   <= par_bit_d;
      frm_err_q   <= frm_err_d;
      stop_zero_q <= stop_zero_d;
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      overrun_q   <= overrun_d;
    end
  end

  assign {m_brk, m_frm_err, m_par_err, m_data} = mem_q[rd_ptr_q];
  assign m_valid    = (level_q != '0);
  assign fifo_level = level_q;
  assign overrun    = overrun_q;

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Next-generation UART receiver with the following features:
- Configurable frame format: 5–9 data bits, none/even/odd parity, 1 or 2 stop bits.
- Configurable oversampling ratio, with a 2-flop input synchroniser and 3-sample majority voting per bit.
- Per-frame error flags (parity, framing, break) and sticky overrun.
- Received frames are buffered in a small FIFO and presented on a valid/ready stream toward the APB register block.

Parameters:
- DATA_BITS, 8: data bits per frame; legal range 5..9.
- PAR_MODE, 1: 0 = no parity, 1 = even, 2 = odd.
- STOP_BITS, 1: 1 or 2.
- OVS, 16: ticks per bit; even, ≥ 8.
- FIFO_DEPTH, 4: entries; power of 2, ≥ 2.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- tick  in  1  single-clk oversample strobe, OVS per bit period
- rx  in  1  serial line, asynchronous, idle high
- m_data  out  DATA_BITS  head-entry data, LSB = first bit received
- m_par_err  out  1  head-entry parity error
- m_frm_err  out  1  head-entry framing error
- m_brk  out  1  head-entry break
- m_valid  out  1  FIFO not empty
- m_ready  in  1  consumer accepts the head entry
- fifo_level  out  $clog2(FIFO_DEPTH)+1  entries held
- overrun  out  1  sticky: a frame was dropped because the FIFO was full
- clr_ovr  in  1  clears overrun

Behaviour:
- Reset (async, rst_n = 0):
  - FSM goes to IDLE; all counters cleared.
  - Synchroniser flops set to 1.
  - FIFO emptied and storage cleared.
  - All outputs 0.
  - Applies mid-frame too: the partial frame is discarded.
- Input path:
  - rx passes through a 2-flop synchroniser to give rx_s; rx_prev is rx_s delayed by one clk.
  - All FSM activity other than IDLE edge detection advances only on tick = 1.
- Bit timing:
  - tick_cnt is 0..OVS-1 and is cleared on entry to START.
  - Within each bit window, rx_s is sampled on the ticks where tick_cnt = OVS/2-1, OVS/2 and OVS/2+1.
  - The bit value is the majority of those three samples, decided on the tick where tick_cnt = OVS/2+1.
  - A bit window ends on the tick where tick_cnt = OVS-1; tick_cnt then wraps to 0.
- FSM states:
  - IDLE: on a falling edge (rx_prev = 1, rx_s = 0) go to START. Since rx_s resets to 1, a line held low through reset produces an edge on release.
  - START: at the decision tick, if the majority is 1 (glitch) return to IDLE with nothing pushed; otherwise continue. At window end go to DATA.
  - DATA: shift in DATA_BITS bits, LSB first. After the last window go to PARITY if PAR_MODE ≠ 0, else STOP.
  - PARITY: capture the voted parity bit. par_err = XOR(data, parity bit) for even; XNOR for odd; always 0 when PAR_MODE = 0.
  - STOP: vote each stop bit; frm_err = 1 if any voted stop bit is 0.
    - On the decision tick of the final stop bit, the frame is pushed on that clk edge (no wait for window end).
    - brk = 1 when data = 0, parity bit = 0 (if present) and stop bit = 0; brk forces frm_err = 1.
    - Next state is BRK_WAIT if brk, else IDLE.
  - BRK_WAIT: remain until rx_s = 1, then go to IDLE. Exactly one entry is pushed per break.
  - Illegal encodings go to IDLE.
- FIFO:
  - Entry = {brk, frm_err, par_err, data}.
  - Head outputs are driven from registered storage.
  - m_valid = (level ≠ 0); m_valid rises the clk after a push into an empty FIFO.
  - Pop occurs when m_valid && m_ready; the next entry appears the following cycle.
- FIFO boundary conditions:
  - Push and pop in the same cycle: both take effect; level is unchanged, including when full.
  - Push while full with no pop: frame dropped, contents unchanged, overrun set the next cycle.
  - clr_ovr and a drop in the same cycle: overrun stays 1 (set wins).
  - Pointers wrap modulo FIFO_DEPTH.
  - fifo_level never exceeds FIFO_DEPTH.
- Latency: from the decision tick of the final stop bit to m_valid is 1 clk (FIFO previously empty).

Test Plan:
Defaults unless stated: DATA_BITS = 8, PAR_MODE = 1 (even), STOP_BITS = 1, OVS = 16, FIFO_DEPTH = 4, tick every 4 clk.
1. Send 0xA5 with parity 0 and stop 1 → one entry: m_data = 0xA5, all flags 0, fifo_level = 1. m_ready pulse → level 0, m_valid = 0.
2. Send 0x3C with parity bit 1 → m_data = 0x3C, m_par_err = 1. Send 0x81 with stop bit 0 → m_frm_err = 1, m_brk = 0.
3. Majority voting and glitch rejection:
   - Force rx low for 3 ticks only → FSM returns to IDLE, level stays 0.
   - Invert a single mid-sample (tick OVS/2) of data bit 2 of 0x00 → received 0x00 with no error.
4. Hold rx low for 12 bit-times, then high → exactly one entry: m_data = 0x00, m_brk = 1, m_frm_err = 1. A following 0x55 frame is received cleanly.
5. With m_ready = 0, send 0x01..0x05 → level 4, 0x05 dropped, overrun = 1. Drain → 0x01..0x04 in order. clr_ovr → overrun = 0.
6. Assert rst_n = 0 mid-DATA → all outputs 0 asynchronously. After release, frame 0x5A is received correctly.
7. Repeat test 1 with PAR_MODE = 0, STOP_BITS = 2, DATA_BITS = 7.
